coe_buf_reader: RTL and testbench

//  Read engine for the single-port coefficient buffer (192 words x PIXEL_WIDTH*8).
//  On start, fetches len_i consecutive words from base_addr_i, wrapping at DEPTH,
//  and streams them downstream on a valid/ready interface. Absorbs the RAM's
//  1-cycle read latency and downstream backpressure without losing or duplicating words.

---
 rtl/coe_buf_reader_pkg.sv | 29 ++
 rtl/coe_buf_skid_fifo.sv | 77 +++++++
 rtl/coe_buf_reader.sv | 147 ++++++++++++++
 tb/tb_coe_buf_reader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coe_buf_reader_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | coe_buf_reader_pkg : shared widths, depth and FSM codes for the coefficient  |
// | buffer read engine.  Rev 1.0                                                 |
// +---------------------------------------------------------------------------+
package coe_buf_reader_pkg;

   localparam int PIXEL_WIDTH   = 8;
   localparam int COE_BUF_DEPTH = 192;
   localparam int COE_DATA_W    = PIXEL_WIDTH * 8;
   localparam int COE_ADDR_W    = 8;

   typedef logic [1:0] coe_rd_state_t;

   localparam logic [1:0] COE_RD_IDLE  = 2'd0;
   localparam logic [1:0] COE_RD_READ  = 2'd1;
   localparam logic [1:0] COE_RD_DRAIN = 2'd2;
   localparam logic [1:0] COE_RD_DONE  = 2'd3;

   // Words held in the FIFO or still coming out of the RAM once this edge retires.
   function automatic logic [2:0] coe_occupancy(input logic [1:0] cnt,
                                                input logic       inflight,
                                                input logic       pop);
      return {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
   endfunction

endpackage

`default_nettype wire

// File: rtl/coe_buf_skid_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | coe_buf_skid_fifo : 2-entry FIFO whose head is a register driving the      |
// | output directly; rst_n doubles as a synchronous flush.  Rev 1.0            |
// +---------------------------------------------------------------------------+
module coe_buf_skid_fifo
   import coe_buf_reader_pkg::*;
#(
   parameter int DATA_W = COE_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [1:0]        cnt_o,
   output logic [DATA_W-1:0] head_o
);

   logic [1:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] tail_q, tail_d;
   logic              do_pop;

   assign do_pop = pop_i && (cnt_q != 2'd0);

   always_comb begin
      cnt_d  = cnt_q;
      head_d = head_q;
      tail_d = tail_q;
      case ({push_i, do_pop})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               head_d = data_i;
               cnt_d  = 2'd1;
            end else if (cnt_q == 2'd1) begin
               tail_d = data_i;
               cnt_d  = 2'd2;
            end
         end
         2'b01: begin
            if (cnt_q == 2'd2) begin
               head_d = tail_q;
            end
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            // Count is unchanged; the incoming word queues behind whatever remains.
            if (cnt_q == 2'd2) begin
               head_d = tail_q;
               tail_d = data_i;
            end else begin
               head_d = data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign head_o = head_q;

endmodule

`default_nettype wire

// File: rtl/coe_buf_reader.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | coe_buf_reader : streams len words from the coefficient RAM, wrapping at   |
// | DEPTH. Optional abort via COE_BUF_RD_ABORT_EN.  Rev 1.0                    |
// +---------------------------------------------------------------------------+
module coe_buf_reader
   import coe_buf_reader_pkg::*;
#(
   parameter int DATA_W = COE_DATA_W,
   parameter int ADDR_W = COE_ADDR_W,
   parameter int DEPTH  = COE_BUF_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W-1:0] len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              ram_ce_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   input  logic [DATA_W-1:0] ram_data_i,
   output logic              val_o,
   output logic [DATA_W-1:0] data_o,
`ifdef COE_BUF_RD_ABORT_EN
   input  logic              abort_i,
`endif
   input  logic              rdy_i
);

   coe_rd_state_t     state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] rem_q, rem_d;
   logic              inflight_q, inflight_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [1:0]        fifo_cnt;
   logic [2:0]        occ;
   logic [ADDR_W-1:0] addr_inc;
   logic              pop;
   logic              issue;
   logic              abort_hit;
   logic              fifo_rst_n;

`ifdef COE_BUF_RD_ABORT_EN
   assign abort_hit = abort_i && ((state_q == COE_RD_READ) || (state_q == COE_RD_DRAIN));
`else
   assign abort_hit = 1'b0;
`endif

   assign val_o = (fifo_cnt != 2'd0);
   assign pop   = val_o && rdy_i;

   // Crediting the same-cycle pop keeps one word per clock under a steady rdy_i.
   assign occ   = coe_occupancy(fifo_cnt, inflight_q, pop);
   assign issue = (state_q == COE_RD_READ) && (rem_q != '0) && (occ < 3'd2) && !abort_hit;

   assign addr_inc = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      inflight_d = issue;
      case (state_q)
         COE_RD_IDLE: begin
            if (start_i) begin
               addr_d  = base_addr_i;
               rem_d   = len_i;
               busy_d  = 1'b1;
               state_d = (len_i == '0) ? COE_RD_DONE : COE_RD_READ;
            end
         end
         COE_RD_READ: begin
            if (issue) begin
               addr_d = addr_inc;
               rem_d  = rem_q - 1'b1;
               if (rem_q == ADDR_W'(1)) begin
                  state_d = COE_RD_DRAIN;
               end
            end
         end
         COE_RD_DRAIN: begin
            if (occ == 3'd0) begin
               state_d = COE_RD_DONE;
            end
         end
         COE_RD_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = COE_RD_IDLE;
         end
         default: state_d = COE_RD_IDLE;
      endcase
      if (abort_hit) begin
         state_d    = COE_RD_IDLE;
         busy_d     = 1'b0;
         inflight_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= COE_RD_IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         inflight_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         inflight_q <= inflight_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // An abort empties the FIFO on the same edge the FSM returns to IDLE.
   assign fifo_rst_n = rst_n && !abort_hit;

   coe_buf_skid_fifo #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (fifo_rst_n),
      .push_i (inflight_q),
      .data_i (ram_data_i),
      .pop_i  (pop),
      .cnt_o  (fifo_cnt),
      .head_o (data_o)
   );

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign ram_ce_o   = issue;
   assign ram_we_o   = 1'b0;
   assign ram_addr_o = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_coe_buf_reader.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_coe_buf_reader : scoreboard bench for coe_buf_reader; abort scenario    |
// | included when COE_BUF_RD_ABORT_EN is defined.  Rev 1.0                     |
// +---------------------------------------------------------------------------+
module tb_coe_buf_reader;

   localparam int DW    = 64;
   localparam int AW    = 8;
   localparam int DEPTH = 192;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_i;
   logic [AW-1:0] base_addr_i;
   logic [AW-1:0] len_i;
   logic          busy_o;
   logic          done_o;
   logic          ram_ce_o;
   logic          ram_we_o;
   logic [AW-1:0] ram_addr_o;
   logic [DW-1:0] ram_data;
   logic          val_o;
   logic [DW-1:0] data_o;
   logic          rdy_i;
`ifdef COE_BUF_RD_ABORT_EN
   logic          abort_i;
`endif

   always #5 clk = ~clk;

   coe_buf_reader dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .len_i       (len_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .ram_ce_o    (ram_ce_o),
      .ram_we_o    (ram_we_o),
      .ram_addr_o  (ram_addr_o),
      .ram_data_i  (ram_data),
      .val_o       (val_o),
      .data_o      (data_o),
`ifdef COE_BUF_RD_ABORT_EN
      .abort_i     (abort_i),
`endif
      .rdy_i       (rdy_i)
   );

   function automatic logic [DW-1:0] word_of(input int a);
      logic [31:0] u;
      u = 32'(a);
      return {32'hC0EF_0000 | u, (u * 32'h0101_0101) ^ 32'h5A5A_0000};
   endfunction

   // Preloaded RAM: content is a pure function of the address, 1-cycle read latency.
   always @(posedge clk) begin
      if (ram_ce_o) ram_data <= word_of(int'(ram_addr_o));
   end

   int            tests = 0;
   int            fails = 0;
   logic [DW-1:0] exp_q[$];
   logic [AW-1:0] addr_q[$];
   int            issued = 0;
   int            popped = 0;
   int            done_seen = 0;
   int            exp_done = 0;
   int            words_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT issues a read or hands over a word.
   initial begin
      logic          hold_pend;
      logic [DW-1:0] hold_val;
      logic          pop_now;
      hold_pend = 1'b0;
      hold_val  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_pend = 1'b0;
            issued    = 0;
            popped    = 0;
         end else begin
            if (hold_pend) begin
               check("hold_val", 64'(val_o), 64'd1);
               check("hold_data", data_o, hold_val);
            end
            hold_pend = val_o && !rdy_i;
            hold_val  = data_o;
            pop_now   = val_o && rdy_i;
            if (ram_ce_o) begin
               check("ce_gated", 64'((issued - popped - int'(pop_now)) < 2), 64'd1);
               check("addr_range", 64'(int'(ram_addr_o) < DEPTH), 64'd1);
               check("we_zero", 64'(ram_we_o), 64'd0);
               if (addr_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_read: addr %0d, none expected", ram_addr_o);
               end else begin
                  check("rd_addr", 64'(ram_addr_o), 64'(addr_q.pop_front()));
               end
               issued++;
            end
            if (pop_now) begin
               if (exp_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_word: got %h, none expected", data_o);
               end else begin
                  check("word", data_o, exp_q.pop_front());
               end
               popped++;
               words_seen++;
            end
            if (done_o) done_seen++;
         end
      end
   end

   task automatic start_job(input int base, input int len);
      for (int i = 0; i < len; i++) begin
         exp_q.push_back(word_of((base + i) % DEPTH));
         addr_q.push_back(AW'((base + i) % DEPTH));
      end
      base_addr_i = AW'(base);
      len_i       = AW'(len);
      start_i     = 1'b1;
      @(posedge clk); #1;
      start_i     = 1'b0;
   endtask

   task automatic run_job(input string name, input int len, input logic [15:0] pat,
                          input bit full_rate, input bit spurious);
      int nval;
      int first;
      int last;
      bit got;
      nval  = 0;
      first = -1;
      last  = -1;
      got   = 1'b0;
      for (int k = 0; k < 300 && !got; k++) begin
         rdy_i = pat[k % 16];
         if (spurious && k == 2) begin
            base_addr_i = AW'(50);
            len_i       = AW'(3);
            start_i     = 1'b1;
         end else begin
            start_i     = 1'b0;
         end
         @(posedge clk); #1;
         if (val_o) begin
            nval++;
            if (first < 0) first = k;
            last = k;
         end
         if (done_o) begin
            got = 1'b1;
            check({name, "_busy_drop"}, 64'(busy_o), 64'd0);
         end
      end
      start_i = 1'b0;
      rdy_i   = 1'b1;
      check({name, "_done_seen"}, 64'(got), 64'd1);
      check({name, "_all_words"}, 64'(exp_q.size()), 64'd0);
      if (full_rate) begin
         check({name, "_val_cycles"}, 64'(nval), 64'(len));
         check({name, "_val_span"}, 64'(last - first + 1), 64'(len));
      end
      exp_done++;
      repeat (3) @(posedge clk);
      #1;
      check({name, "_done_once"}, 64'(done_seen), 64'(exp_done));
      check({name, "_idle_busy"}, 64'(busy_o), 64'd0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_busy"}, 64'(busy_o), 64'd0);
      check({name, "_done"}, 64'(done_o), 64'd0);
      check({name, "_ce"}, 64'(ram_ce_o), 64'd0);
      check({name, "_val"}, 64'(val_o), 64'd0);
      check({name, "_addr"}, 64'(ram_addr_o), 64'd0);
      check({name, "_data"}, data_o, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   initial begin
      int base_w;
      rst_n       = 1'b0;
      start_i     = 1'b0;
      base_addr_i = '0;
      len_i       = '0;
      rdy_i       = 1'b1;
`ifdef COE_BUF_RD_ABORT_EN
      abort_i     = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Straight run with a start pulse mid-job that must be ignored.
      start_job(0, 8);
      run_job("base0", 8, 16'hFFFF, 1'b1, 1'b1);

      // Wrap from the top of the buffer back to address 0.
      start_job(188, 8);
      run_job("wrap", 8, 16'hFFFF, 1'b1, 1'b0);

      // Irregular backpressure.
      rdy_i = 1'b0;
      start_job(20, 8);
      run_job("bp", 8, 16'b1001_0110_0011_1010, 1'b0, 1'b0);

      // Zero-length job: done two cycles after start, no RAM access.
      start_job(5, 0);
      check("len0_busy", 64'(busy_o), 64'd1);
      check("len0_done_early", 64'(done_o), 64'd0);
      @(posedge clk); #1;
      check("len0_done", 64'(done_o), 64'd1);
      check("len0_busy_drop", 64'(busy_o), 64'd0);
      exp_done++;
      repeat (3) @(posedge clk);
      #1;
      check("len0_done_once", 64'(done_seen), 64'(exp_done));

      // Reset after the third word, then a clean job.
      base_w = words_seen;
      start_job(100, 8);
      for (int k = 0; k < 50 && words_seen < base_w + 3; k++) @(posedge clk);
      #1;
      check("rst_reach3", 64'(words_seen >= base_w + 3), 64'd1);
      rst_n = 1'b0;
      exp_q.delete();
      addr_q.delete();
      @(posedge clk); #1;
      check_all_zero("midrst");
      rst_n = 1'b1;
      start_job(7, 5);
      run_job("after_rst", 5, 16'hFFFF, 1'b1, 1'b0);

`ifdef COE_BUF_RD_ABORT_EN
      base_w = words_seen;
      start_job(30, 16);
      for (int k = 0; k < 50 && words_seen < base_w + 4; k++) @(posedge clk);
      #1;
      check("abort_reach4", 64'(words_seen >= base_w + 4), 64'd1);
      abort_i = 1'b1;
      @(posedge clk); #1;
      abort_i = 1'b0;
      exp_q.delete();
      addr_q.delete();
      issued = 0;
      popped = 0;
      check("abort_ce", 64'(ram_ce_o), 64'd0);
      check("abort_val", 64'(val_o), 64'd0);
      check("abort_busy", 64'(busy_o), 64'd0);
      repeat (4) @(posedge clk);
      #1;
      check("abort_no_done", 64'(done_seen), 64'(exp_done));
      start_job(60, 4);
      run_job("after_abort", 4, 16'hFFFF, 1'b1, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
